// File: rtl/ysyx_ifu_fetch_if.sv
// Fetch-unit bundle: instruction-bus request/response, redirect, and decode-side
// output. master = fetch unit, slave = the arbiter/decode/redirect environment.
interface ysyx_ifu_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] ifu_araddr;
    logic              ifu_arvalid;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_rvalid;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic [DATA_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              out_ready;

    modport master (
        output ifu_araddr, ifu_arvalid, out_valid, out_inst, out_pc,
        input  ifu_rdata, ifu_rvalid, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  ifu_araddr, ifu_arvalid, out_valid, out_inst, out_pc,
        output ifu_rdata, ifu_rvalid, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/ysyx_ifu_fetch.sv
// Instruction fetch unit: issues one outstanding bus read at a time into a
// 2-entry {pc, inst} FIFO, with redirect flush and in-flight response discard.
module ysyx_ifu_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h30000000
) (
    input logic              clk,
    input logic              rst,
    ysyx_ifu_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              arvalid_q, arvalid_d;
    logic              started_q, started_d;
    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] fifo_pc_q [2];
    logic [ADDR_W-1:0] fifo_pc_d [2];
    logic [DATA_W-1:0] fifo_inst_q [2];
    logic [DATA_W-1:0] fifo_inst_d [2];

    logic              redirect, push, pop;
    logic [ADDR_W-1:0] pc_inc;

    always_comb begin
        redirect    = bus.redirect_valid;
        pc_inc      = pc_q + ADDR_W'(4);
        pop         = (count_q != 2'd0) && bus.out_ready && !redirect;
        push        = (state_q == REQ) && bus.ifu_rvalid && !redirect;

        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        started_d   = 1'b1;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;

        if (redirect) begin
            count_d  = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                fifo_pc_d[wr_ptr_q]   = req_addr_q;
                fifo_inst_d[wr_ptr_q] = bus.ifu_rdata;
                wr_ptr_d              = ~wr_ptr_q;
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end

        // started_q holds off the first request one cycle past reset release
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = bus.redirect_pc;
                end else if (started_q && count_d != 2'd2) begin
                    state_d    = REQ;
                    req_addr_d = pc_q;
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_d    = bus.redirect_pc;
                    state_d = bus.ifu_rvalid ? IDLE : DISCARD;
                end else if (bus.ifu_rvalid) begin
                    pc_d = pc_inc;
                    if (count_d != 2'd2) req_addr_d = pc_inc;
                    else                 state_d    = IDLE;
                end
            end
            DISCARD: begin
                if (redirect)       pc_d    = bus.redirect_pc;
                if (bus.ifu_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        arvalid_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= '0;
            arvalid_q   <= 1'b0;
            started_q   <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_pc_q   <= '{default: '0};
            fifo_inst_q <= '{default: '0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            arvalid_q   <= arvalid_d;
            started_q   <= started_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_inst_q <= fifo_inst_d;
        end
    end

    assign bus.ifu_araddr  = DATA_W'(req_addr_q);
    assign bus.ifu_arvalid = arvalid_q;
    assign bus.out_valid   = (count_q != 2'd0);
    assign bus.out_inst    = fifo_inst_q[rd_ptr_q];
    assign bus.out_pc      = fifo_pc_q[rd_ptr_q];
endmodule

// File: tb/tb_ysyx_ifu_fetch.sv
// Directed bench for ysyx_ifu_fetch: each scenario task continues from the
// state the previous one leaves behind.
module tb_ysyx_ifu_fetch;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ysyx_ifu_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ysyx_ifu_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h30000000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ifu_rdata = '0;
        bus.ifu_rvalid = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b0;
        #1;
        tick();
        tick();
        checks++;
        if (bus.ifu_arvalid !== 1'b0) begin
            errors++; $display("FAIL reset_arvalid got %b exp 0", bus.ifu_arvalid);
        end
        checks++;
        if (bus.ifu_araddr !== 32'h0) begin
            errors++; $display("FAIL reset_araddr got %h exp 00000000", bus.ifu_araddr);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.ifu_arvalid !== 1'b0) begin
            errors++; $display("FAIL first_edge_arvalid got %b exp 0", bus.ifu_arvalid);
        end
        tick();
        checks++;
        if (bus.ifu_arvalid !== 1'b1 || bus.ifu_araddr !== 32'h30000000) begin
            errors++;
            $display("FAIL second_edge_req got %b/%h exp 1/30000000", bus.ifu_arvalid, bus.ifu_araddr);
        end
    endtask

    task automatic test_first_fetch();
        tick();
        tick();
        bus.ifu_rvalid = 1'b1;
        bus.ifu_rdata = 32'h00000413;
        tick();
        bus.ifu_rvalid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h30000000 || bus.out_inst !== 32'h00000413) begin
            errors++;
            $display("FAIL first_fetch_out got %b/%h/%h exp 1/30000000/00000413",
                     bus.out_valid, bus.out_pc, bus.out_inst);
        end
        checks++;
        if (bus.ifu_arvalid !== 1'b1 || bus.ifu_araddr !== 32'h30000004) begin
            errors++;
            $display("FAIL first_fetch_next_req got %b/%h exp 1/30000004", bus.ifu_arvalid, bus.ifu_araddr);
        end
    endtask

    task automatic test_fifo_full();
        bus.ifu_rvalid = 1'b1;
        bus.ifu_rdata = 32'h0000A0A0;
        tick();
        bus.ifu_rvalid = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.ifu_arvalid !== 1'b0) begin
            errors++; $display("FAIL full_arvalid got %b exp 0", bus.ifu_arvalid);
        end
        checks++;
        if (bus.out_pc !== 32'h30000000 || bus.out_inst !== 32'h00000413) begin
            errors++; $display("FAIL full_head got %h/%h exp 30000000/00000413", bus.out_pc, bus.out_inst);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.ifu_arvalid !== 1'b1 || bus.ifu_araddr !== 32'h30000008) begin
            errors++;
            $display("FAIL after_pop_req got %b/%h exp 1/30000008", bus.ifu_arvalid, bus.ifu_araddr);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h30000004 || bus.out_inst !== 32'h0000A0A0) begin
            errors++;
            $display("FAIL after_pop_head got %b/%h/%h exp 1/30000004/0000a0a0",
                     bus.out_valid, bus.out_pc, bus.out_inst);
        end
    endtask

    task automatic test_discard();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h80000000;
        tick();
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL discard_flush got %b exp 0", bus.out_valid);
        end
        checks++;
        if (bus.ifu_arvalid !== 1'b1 || bus.ifu_araddr !== 32'h30000008) begin
            errors++;
            $display("FAIL discard_hold got %b/%h exp 1/30000008", bus.ifu_arvalid, bus.ifu_araddr);
        end
        tick();
        tick();
        bus.ifu_rvalid = 1'b1;
        bus.ifu_rdata = 32'hDEADDEAD;
        tick();
        bus.ifu_rvalid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ifu_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL discard_drop got %b/%b exp 0/0", bus.out_valid, bus.ifu_arvalid);
        end
        tick();
        checks++;
        if (bus.ifu_arvalid !== 1'b1 || bus.ifu_araddr !== 32'h80000000) begin
            errors++;
            $display("FAIL discard_restart got %b/%h exp 1/80000000", bus.ifu_arvalid, bus.ifu_araddr);
        end
    endtask

    task automatic test_redirect_with_rvalid();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h90000000;
        bus.ifu_rvalid = 1'b1;
        bus.ifu_rdata = 32'hBEEFBEEF;
        tick();
        bus.redirect_valid = 1'b0;
        bus.ifu_rvalid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ifu_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL redir_rvalid_empty got %b/%b exp 0/0", bus.out_valid, bus.ifu_arvalid);
        end
        tick();
        checks++;
        if (bus.ifu_arvalid !== 1'b1 || bus.ifu_araddr !== 32'h90000000) begin
            errors++;
            $display("FAIL redir_rvalid_req got %b/%h exp 1/90000000", bus.ifu_arvalid, bus.ifu_araddr);
        end
    endtask

    task automatic test_lsu_stall();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.ifu_arvalid !== 1'b1 || bus.ifu_araddr !== 32'h90000000 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d got %b/%h/%b exp 1/90000000/0",
                         i, bus.ifu_arvalid, bus.ifu_araddr, bus.out_valid);
            end
        end
        bus.ifu_rvalid = 1'b1;
        bus.ifu_rdata = 32'h00000011;
        tick();
        bus.ifu_rvalid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h90000000 || bus.out_inst !== 32'h00000011
            || bus.ifu_araddr !== 32'h90000004) begin
            errors++;
            $display("FAIL stall_done got %b/%h/%h/%h exp 1/90000000/00000011/90000004",
                     bus.out_valid, bus.out_pc, bus.out_inst, bus.ifu_araddr);
        end
    endtask

    task automatic test_wrap();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFFFFFC;
        tick();
        bus.redirect_valid = 1'b0;
        bus.ifu_rvalid = 1'b1;
        tick();
        bus.ifu_rvalid = 1'b0;
        tick();
        checks++;
        if (bus.ifu_arvalid !== 1'b1 || bus.ifu_araddr !== 32'hFFFFFFFC || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_req got %b/%h/%b exp 1/fffffffc/0", bus.ifu_arvalid, bus.ifu_araddr, bus.out_valid);
        end
        bus.ifu_rvalid = 1'b1;
        bus.ifu_rdata = 32'h00000022;
        tick();
        bus.ifu_rvalid = 1'b0;
        checks++;
        if (bus.out_pc !== 32'hFFFFFFFC || bus.out_inst !== 32'h00000022) begin
            errors++; $display("FAIL wrap_head got %h/%h exp fffffffc/00000022", bus.out_pc, bus.out_inst);
        end
        checks++;
        if (bus.ifu_arvalid !== 1'b1 || bus.ifu_araddr !== 32'h00000000) begin
            errors++;
            $display("FAIL wrap_next got %b/%h exp 1/00000000", bus.ifu_arvalid, bus.ifu_araddr);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        bus.ifu_rvalid = 1'b1;
        bus.ifu_rdata = 32'h00000033;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h00000000 || bus.out_inst !== 32'h00000033
            || bus.ifu_araddr !== 32'h00000004) begin
            errors++;
            $display("FAIL b2b_first got %b/%h/%h/%h exp 1/00000000/00000033/00000004",
                     bus.out_valid, bus.out_pc, bus.out_inst, bus.ifu_araddr);
        end
        bus.ifu_rdata = 32'h00000044;
        tick();
        bus.out_ready = 1'b0;
        bus.ifu_rvalid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h00000004 || bus.out_inst !== 32'h00000044
            || bus.ifu_arvalid !== 1'b1 || bus.ifu_araddr !== 32'h00000008) begin
            errors++;
            $display("FAIL b2b_second got %b/%h/%h/%b/%h exp 1/00000004/00000044/1/00000008",
                     bus.out_valid, bus.out_pc, bus.out_inst, bus.ifu_arvalid, bus.ifu_araddr);
        end
    endtask

    task automatic test_reset_mid_request();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.ifu_arvalid !== 1'b0 || bus.out_valid !== 1'b0 || bus.ifu_araddr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got %b/%b/%h exp 0/0/00000000",
                     bus.ifu_arvalid, bus.out_valid, bus.ifu_araddr);
        end
        tick();
        rst = 1'b0;
        bus.ifu_rvalid = 1'b1;
        bus.ifu_rdata = 32'h55555555;
        tick();
        bus.ifu_rvalid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ifu_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_drop got %b/%b exp 0/0", bus.out_valid, bus.ifu_arvalid);
        end
        tick();
        checks++;
        if (bus.ifu_arvalid !== 1'b1 || bus.ifu_araddr !== 32'h30000000) begin
            errors++;
            $display("FAIL post_reset_req got %b/%h exp 1/30000000", bus.ifu_arvalid, bus.ifu_araddr);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_first_fetch();
        test_fifo_full();
        test_discard();
        test_redirect_with_rvalid();
        test_lsu_stall();
        test_wrap();
        test_back_to_back();
        test_reset_mid_request();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_ifu_fetch.md
YSYX_IFU_FETCH -- requirements
Module: ysyx_ifu_fetch

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, instruction/data width.
REQ-003 Parameter RESET_PC, default 32'h30000000, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ifu_araddr  output  DATA_W  fetch address to bus arbiter.
REQ-007 ifu_arvalid  output  1  fetch request to bus arbiter.
REQ-008 ifu_rdata  input  DATA_W  instruction word from arbiter; valid only when ifu_rvalid=1.
REQ-009 ifu_rvalid  input  1  one-cycle completion pulse from arbiter.
REQ-010 redirect_valid  input  1  flush and restart fetch at redirect_pc.
REQ-011 redirect_pc  input  ADDR_W  new fetch PC.
REQ-012 out_valid  output  1  instruction available to decode.
REQ-013 out_inst  output  DATA_W  instruction at FIFO head.
REQ-014 out_pc  output  ADDR_W  PC of out_inst.
REQ-015 out_ready  input  1  decode accepts head this cycle.

Function
REQ-016 Internal 2-entry FIFO of {pc, inst}; count 0..2; head drives out_inst/out_pc; out_valid = (count != 0).
REQ-017 FSM states: IDLE, REQ, DISCARD; ifu_arvalid = (state==REQ || state==DISCARD), driven from registers only.
REQ-018 ifu_araddr shall equal the registered req_addr and stay constant while ifu_arvalid=1.
REQ-019 The arbiter has no arready; ifu_arvalid shall remain high until ifu_rvalid is sampled high, with no early deassert.
REQ-020 IDLE -> REQ when count_next < 2 and no redirect; req_addr <= pc.
REQ-021 REQ, ifu_rvalid=1, no redirect: push {req_addr, ifu_rdata} the same cycle, pc <= pc+4, then REQ (req_addr <= pc+4) if count_next < 2, else IDLE; back-to-back fetch permitted.
REQ-022 REQ, redirect_valid=1 and ifu_rvalid=0: pc <= redirect_pc, flush FIFO, go to DISCARD.
REQ-023 REQ, redirect_valid=1 and ifu_rvalid=1: drop returned word, flush FIFO, pc <= redirect_pc, go to IDLE.
REQ-024 DISCARD: hold arvalid/araddr; on ifu_rvalid drop data and go to IDLE; a further redirect only updates pc.
REQ-025 IDLE with redirect: flush FIFO, pc <= redirect_pc, stay IDLE that cycle.
REQ-026 Pop when out_valid && out_ready && !redirect_valid; redirect wins over pop and push.
REQ-027 Simultaneous push and pop: count unchanged, ordering preserved.
REQ-028 Requests are issued only with guaranteed space; push into a full FIFO shall never occur.
REQ-029 PC arithmetic is modulo 2^ADDR_W; 32'hFFFFFFFC + 4 wraps to 0.
REQ-030 Responses arrive only through ifu_rvalid; cycles where the arbiter masks rvalid for LSU priority are plain wait cycles.

Reset
REQ-031 On rst: state=IDLE, pc=RESET_PC, count=0, FIFO pointers 0, ifu_arvalid=0, ifu_araddr=0, out_valid=0.
REQ-032 rst asserted mid-request: drop arvalid immediately and discard any response arriving after reset release.
REQ-033 First ifu_arvalid shall occur in the second posedge after rst deasserts, with address RESET_PC.

Verification
REQ-034 Reset release, rvalid after 3 cycles with 32'h00000413 -> araddr=32'h30000000; out_valid=1 next cycle, out_pc=32'h30000000, out_inst=32'h00000413.
REQ-035 out_ready=0, two responses -> count=2, arvalid drops; after one pop the next request has araddr=32'h30000008.
REQ-036 Redirect to 32'h80000000 while a request is waiting -> DISCARD; late rvalid data not enqueued; next araddr=32'h80000000.
REQ-037 Redirect and rvalid in the same cycle -> FIFO empty next cycle, next request has araddr=redirect_pc.
REQ-038 rvalid held low 10 cycles for LSU priority -> arvalid and araddr stable throughout, no push.
REQ-039 pc=32'hFFFFFFFC fetch completes -> next araddr=32'h00000000.
